// File: rtl/simple_cpu_pkg.sv
// rtl/simple_cpu_pkg.sv - shared opcode classes, field positions and sequencer states
package simple_cpu_pkg;

  localparam logic [1:0] CLS_NOP   = 2'b00;
  localparam logic [1:0] CLS_ALU   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  localparam int CLS_HI    = 19;
  localparam int CLS_LO    = 18;
  localparam int X1_HI     = 17;
  localparam int X1_LO     = 16;
  localparam int X2_HI     = 15;
  localparam int X2_LO     = 14;
  localparam int X3_HI     = 13;
  localparam int X3_LO     = 12;
  localparam int IMM_HI    = 11;
  localparam int IMM_LO    = 4;
  localparam int FUNCT_BIT = 0;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_FINISH = 2'd2
  } seq_state_t;

  // A configured hold of zero would make an entry invisible, so it is promoted to one cycle.
  function automatic int unsigned at_least_one(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/instr_prog_mem.sv
// rtl/instr_prog_mem.sv - program store, synchronous write, combinational read
module instr_prog_mem #(
  parameter int WIDTH     = 20,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - issues stored instructions to simple_cpu, each held for its class hold count
module instr_sequencer
  import simple_cpu_pkg::*;
#(
  parameter int INSTR_WIDTH    = 20,
  parameter int PROG_ADDR_BITS = 4,
  parameter int ALU_HOLD       = 3,
  parameter int STORE_HOLD     = 3,
  parameter int LOAD_HOLD      = 4,
  parameter int NOP_HOLD       = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      prog_we,
  input  logic [PROG_ADDR_BITS-1:0] prog_addr,
  input  logic [INSTR_WIDTH-1:0]    prog_data,
  input  logic [PROG_ADDR_BITS:0]   prog_len,
  input  logic                      start,
  input  logic                      abort,
  output logic [INSTR_WIDTH-1:0]    instruction,
  output logic                      instr_valid,
  output logic [PROG_ADDR_BITS-1:0] pc,
  output logic                      busy,
  output logic                      done
);

  localparam int DEPTH = 2**PROG_ADDR_BITS;
  localparam int LEN_W = PROG_ADDR_BITS + 1;

  seq_state_t                state;
  seq_state_t                state_nxt;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          hold_m1;
  logic [LEN_W-1:0]          len;
  logic [LEN_W-1:0]          eff_len;
  logic [PROG_ADDR_BITS-1:0] rd_addr;
  logic [INSTR_WIDTH-1:0]    rd_word;
  logic                      last_entry;
  logic                      mem_we;

  // Store is frozen while a program runs so the issued sequence stays coherent.
  assign mem_we = prog_we && (state == ST_IDLE);

  instr_prog_mem #(
    .WIDTH     (INSTR_WIDTH),
    .ADDR_BITS (PROG_ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  assign rd_addr    = (state == ST_HOLD) ? pc + PROG_ADDR_BITS'(1) : '0;
  assign eff_len    = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
  assign last_entry = ({1'b0, pc} == len - LEN_W'(1));

  always_comb begin
    hold_m1 = '0;
    case (rd_word[INSTR_WIDTH-1 -: 2])
      CLS_ALU:   hold_m1 = CNT_W'(at_least_one(ALU_HOLD) - 1);
      CLS_LOAD:  hold_m1 = CNT_W'(at_least_one(LOAD_HOLD) - 1);
      CLS_STORE: hold_m1 = CNT_W'(at_least_one(STORE_HOLD) - 1);
      CLS_NOP:   hold_m1 = CNT_W'(at_least_one(NOP_HOLD) - 1);
      default:   hold_m1 = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt = (prog_len == '0) ? ST_FINISH : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt == '0 && last_entry) begin
            state_nxt = ST_FINISH;
          end
        end
        ST_FINISH: state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == ST_HOLD);
    done = (state == ST_FINISH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction <= '0;
      instr_valid <= 1'b0;
      pc          <= '0;
      cnt         <= '0;
      len         <= '0;
    end else if (abort) begin
      instruction <= '0;
      instr_valid <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && prog_len != '0) begin
            instruction <= rd_word;
            instr_valid <= 1'b1;
            pc          <= '0;
            cnt         <= hold_m1;
            len         <= eff_len;
          end
        end
        ST_HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!last_entry) begin
            pc          <= rd_addr;
            instruction <= rd_word;
            cnt         <= hold_m1;
          end else begin
            instruction <= '0;
            instr_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
